// File: rtl/exe_stage_if.sv
// ID/EX-to-EXE decode bundle plus EXE/MEM results for the execute stage.
// The stage drives the slave modport, and the ID/MEM side uses master.
interface exe_stage_if #(
  parameter int unsigned DW = 32
);
  logic          wb_en_in;
  logic          mem_r_en_in;
  logic          mem_w_en_in;
  logic [3:0]    exe_cmd;
  logic          b_in;
  logic          s_in;
  logic          imm_in;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] val_rn;
  logic [DW-1:0] val_rm;
  logic [11:0]   shift_operand;
  logic [23:0]   imm_signed_24;
  logic [3:0]    dest_in;
  logic [3:0]    sr_in;
  logic [1:0]    sel_src1;
  logic [1:0]    sel_src2;
  logic [DW-1:0] fwd_mem_val;
  logic [DW-1:0] fwd_wb_val;

  logic          branch_taken;
  logic [DW-1:0] branch_addr;
  logic [3:0]    sr_out;
  logic          wb_en;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] st_val;
  logic [3:0]    dest;

  modport master (
    output wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd, b_in, s_in, imm_in,
           pc_in, val_rn, val_rm, shift_operand, imm_signed_24, dest_in, sr_in,
           sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
    input  branch_taken, branch_addr, sr_out, wb_en, mem_r_en, mem_w_en,
           alu_res, st_val, dest
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, mem_w_en_in, exe_cmd, b_in, s_in, imm_in,
           pc_in, val_rn, val_rm, shift_operand, imm_signed_24, dest_in, sr_in,
           sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
    output branch_taken, branch_addr, sr_out, wb_en, mem_r_en, mem_w_en,
           alu_res, st_val, dest
  );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: forwarding, Val2, ALU, branch target, NZCV and EXE/MEM register.
// Optional macro EXE_FWD_EN enables the operand forwarding muxes (otherwise register values are used).
module exe_stage #(
  parameter int unsigned DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  exe_stage_if.slave  bus
);
  localparam int unsigned SW = 5;

  logic [DW-1:0] op1, rm_f, val2, res;
  logic [DW:0]   sum;
  logic          cin, n_f, z_f, c_f, v_f;
  logic [11:0]   so;

  logic          wb_q, mr_q, mw_q;
  logic [DW-1:0] alu_q, st_q;
  logic [3:0]    dest_q, sr_q;

  function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input logic [SW-1:0] amt);
    logic [2*DW-1:0] t;
    t = {x, x} >> amt;
    return t[DW-1:0];
  endfunction

`ifdef EXE_FWD_EN
  always_comb begin : fwd_mux
    op1  = bus.val_rn;
    rm_f = bus.val_rm;
    case (bus.sel_src1)
      2'b01:   op1 = bus.fwd_mem_val;
      2'b10:   op1 = bus.fwd_wb_val;
      default: op1 = bus.val_rn;
    endcase
    case (bus.sel_src2)
      2'b01:   rm_f = bus.fwd_mem_val;
      2'b10:   rm_f = bus.fwd_wb_val;
      default: rm_f = bus.val_rm;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.sel_src1, bus.sel_src2, bus.fwd_mem_val, bus.fwd_wb_val};
  assign op1  = bus.val_rn;
  assign rm_f = bus.val_rm;
`endif

  assign so  = bus.shift_operand;
  assign cin = bus.sr_in[1];

  // Memory ops use the raw 12-bit offset ahead of any immediate/shift decoding.
  always_comb begin : val2_gen
    val2 = rm_f;
    if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, so};
    end else if (bus.imm_in) begin
      val2 = ror({24'b0, so[7:0]}, {so[11:8], 1'b0});
    end else if (!so[4]) begin
      case (so[6:5])
        2'b00:   val2 = rm_f << so[11:7];
        2'b01:   val2 = rm_f >> so[11:7];
        2'b10:   val2 = DW'($signed(rm_f) >>> so[11:7]);
        default: val2 = ror(rm_f, so[11:7]);
      endcase
    end
  end

  // ADC/SBC share the ADD/SUB paths; opcode bit 0 gates the carry term.
  always_comb begin : alu
    res = '0;
    sum = '0;
    c_f = bus.sr_in[1];
    v_f = bus.sr_in[0];
    case (bus.exe_cmd)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011: begin
        sum = {1'b0, op1} + {1'b0, val2} + (DW+1)'(cin & bus.exe_cmd[0]);
        res = sum[DW-1:0];
        c_f = sum[DW];
        v_f = (op1[DW-1] == val2[DW-1]) && (res[DW-1] != op1[DW-1]);
      end
      4'b0100, 4'b0101: begin
        sum = {1'b0, op1} - {1'b0, val2} - (DW+1)'(~cin & bus.exe_cmd[0]);
        res = sum[DW-1:0];
        c_f = ~sum[DW];
        v_f = (op1[DW-1] != val2[DW-1]) && (res[DW-1] != op1[DW-1]);
      end
      4'b0110: res = op1 & val2;
      4'b0111: res = op1 | val2;
      4'b1000: res = op1 ^ val2;
      default: res = '0;
    endcase
    n_f = res[DW-1];
    z_f = (res == '0);
  end

  logic unused_sr;
  assign unused_sr = ^bus.sr_in[3:2];

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in + {{(DW-26){bus.imm_signed_24[23]}}, bus.imm_signed_24, 2'b00};

  // EXE/MEM pipeline register and NZCV; a stall freezes both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      alu_q  <= '0;
      st_q   <= '0;
      dest_q <= '0;
      sr_q   <= '0;
    end else if (!stall) begin
      wb_q   <= bus.wb_en_in;
      mr_q   <= bus.mem_r_en_in;
      mw_q   <= bus.mem_w_en_in;
      alu_q  <= res;
      st_q   <= rm_f;
      dest_q <= bus.dest_in;
      if (bus.s_in) sr_q <= {n_f, z_f, c_f, v_f};
    end
  end

  assign bus.wb_en    = wb_q;
  assign bus.mem_r_en = mr_q;
  assign bus.mem_w_en = mw_q;
  assign bus.alu_res  = alu_q;
  assign bus.st_val   = st_q;
  assign bus.dest     = dest_q;
  assign bus.sr_out   = sr_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: hand-derived expectations queued at issue, checked after each edge.
module tb_exe_stage;
  logic clk, rst, stall;
  exe_stage_if bus ();

  exe_stage dut (.clk(clk), .rst(rst), .stall(stall), .bus(bus));

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb, mr, mw;
    logic [3:0]  sr;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] cmd, input logic s, input logic imm,
                    input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                    input logic [3:0] d, input logic wb, input logic mr, input logic mw,
                    input logic [3:0] srin);
    bus.exe_cmd = cmd; bus.s_in = s; bus.imm_in = imm;
    bus.val_rn = rn; bus.val_rm = rm; bus.shift_operand = so;
    bus.dest_in = d; bus.wb_en_in = wb; bus.mem_r_en_in = mr; bus.mem_w_en_in = mw;
    bus.sr_in = srin;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d,
                      input logic wb, input logic mr, input logic mw, input logic [3:0] sr);
    exp_t e;
    e.alu = alu; e.st = st; e.dest = d; e.wb = wb; e.mr = mr; e.mw = mw; e.sr = sr;
    q.push_back(e);
    last = e;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_tests++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".alu_res"}, bus.alu_res, e.alu);
      chk({tag, ".st_val"}, bus.st_val, e.st);
      chk({tag, ".dest"}, 32'(bus.dest), 32'(e.dest));
      chk({tag, ".ctl"}, 32'({bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 32'({e.wb, e.mr, e.mw}));
      chk({tag, ".sr_out"}, 32'(bus.sr_out), 32'(e.sr));
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".alu_res"}, bus.alu_res, 32'h0);
    chk({tag, ".st_val"}, bus.st_val, 32'h0);
    chk({tag, ".dest"}, 32'(bus.dest), 32'h0);
    chk({tag, ".ctl"}, 32'({bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 32'h0);
    chk({tag, ".sr_out"}, 32'(bus.sr_out), 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    bus.b_in = 1'b0; bus.pc_in = '0; bus.imm_signed_24 = '0;
    bus.sel_src1 = 2'b00; bus.sel_src2 = 2'b00; bus.fwd_mem_val = '0; bus.fwd_wb_val = '0;
    op(4'h0, 0, 0, 0, 0, 12'h000, 4'h0, 0, 0, 0, 4'h0);
    #2;
    chk_cleared("reset_initial");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADD overflow into the sign bit: N and V set
    op(4'b0010, 1, 1, 32'h7FFF_FFFF, 32'h0000_1234, 12'h001, 4'd3, 1, 0, 0, 4'h0);
    push(32'h8000_0000, 32'h0000_1234, 4'd3, 1, 0, 0, 4'b1001); tick("add_ovf");
    op(4'b0100, 1, 1, 32'd5, 32'h0, 12'h005, 4'd4, 1, 0, 0, 4'h0);
    push(32'h0, 32'h0, 4'd4, 1, 0, 0, 4'b0110); tick("sub_zero");
    op(4'b0100, 0, 1, 32'd3, 32'h0, 12'h005, 4'd4, 1, 0, 0, 4'h0);
    push(32'hFFFF_FFFE, 32'h0, 4'd4, 1, 0, 0, 4'b0110); tick("sub_no_s");

    // Register shifts through MOV
    op(4'b0001, 0, 0, 32'h0, 32'h8000_0001, 12'h0C1, 4'd1, 1, 0, 0, 4'h0);
    push(32'hC000_0000, 32'h8000_0001, 4'd1, 1, 0, 0, 4'b0110); tick("mov_asr1");
    op(4'b0001, 0, 0, 32'h0, 32'h8000_0001, 12'h0E1, 4'd1, 1, 0, 0, 4'h0);
    push(32'hC000_0000, 32'h8000_0001, 4'd1, 1, 0, 0, 4'b0110); tick("mov_ror1");
    op(4'b0001, 0, 0, 32'h0, 32'h8000_0001, 12'h0A1, 4'd1, 1, 0, 0, 4'h0);
    push(32'h4000_0000, 32'h8000_0001, 4'd1, 1, 0, 0, 4'b0110); tick("mov_lsr1");
    op(4'b0010, 0, 0, 32'd1, 32'h8000_0001, 12'h081, 4'd2, 1, 0, 0, 4'h0);
    push(32'h0000_0003, 32'h8000_0001, 4'd2, 1, 0, 0, 4'b0110); tick("add_lsl1");

    // Rotated immediate; C/V pass through from sr_in
    op(4'b0001, 1, 1, 32'h0, 32'h0, 12'h4FF, 4'd6, 1, 0, 0, 4'b0010);
    push(32'hFF00_0000, 32'h0, 4'd6, 1, 0, 0, 4'b1010); tick("mov_imm_rot");
    op(4'b0011, 1, 1, 32'hFFFF_FFFF, 32'h0, 12'h000, 4'd7, 1, 0, 0, 4'b0010);
    push(32'h0, 32'h0, 4'd7, 1, 0, 0, 4'b0110); tick("adc_carry");
    op(4'b0101, 1, 1, 32'h0, 32'h0, 12'h000, 4'd7, 1, 0, 0, 4'b0000);
    push(32'hFFFF_FFFF, 32'h0, 4'd7, 1, 0, 0, 4'b1000); tick("sbc_borrow");

    // Logical ops, MVN and an undefined opcode
    op(4'b0110, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 4'd8, 1, 0, 0, 4'h0);
    push(32'h00F0_00F0, 32'h0FF0_0FF0, 4'd8, 1, 0, 0, 4'b1000); tick("and");
    op(4'b0111, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 4'd8, 1, 0, 0, 4'h0);
    push(32'hFFF0_FFF0, 32'h0FF0_0FF0, 4'd8, 1, 0, 0, 4'b1000); tick("orr");
    op(4'b1000, 1, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 4'd8, 1, 0, 0, 4'b0011);
    push(32'hFF00_FF00, 32'h0FF0_0FF0, 4'd8, 1, 0, 0, 4'b1011); tick("eor_s");
    op(4'b1001, 0, 1, 32'h0, 32'h0, 12'h000, 4'd9, 1, 0, 0, 4'h0);
    push(32'hFFFF_FFFF, 32'h0, 4'd9, 1, 0, 0, 4'b1011); tick("mvn");
    op(4'b1111, 0, 1, 32'h1234, 32'h0, 12'h0FF, 4'd9, 1, 0, 0, 4'h0);
    push(32'h0, 32'h0, 4'd9, 1, 0, 0, 4'b1011); tick("bad_opcode");

    // Memory ops take the raw 12-bit offset even with imm_in set
    op(4'b0010, 0, 1, 32'h0000_1000, 32'h0, 12'hFFF, 4'd10, 1, 1, 0, 4'h0);
    push(32'h0000_1FFF, 32'h0, 4'd10, 1, 1, 0, 4'b1011); tick("ldr_addr");
    op(4'b0010, 0, 0, 32'h0000_2000, 32'hDEAD_BEEF, 12'h004, 4'd0, 0, 0, 1, 4'h0);
    push(32'h0000_2004, 32'hDEAD_BEEF, 4'd0, 0, 0, 1, 4'b1011); tick("str");

    // Forwarding selects
    bus.sel_src1 = 2'b01; bus.fwd_mem_val = 32'd10;
    op(4'b0010, 0, 1, 32'd99, 32'h0, 12'h003, 4'd1, 1, 0, 0, 4'h0);
`ifdef EXE_FWD_EN
    push(32'd13, 32'h0, 4'd1, 1, 0, 0, 4'b1011);
`else
    push(32'd102, 32'h0, 4'd1, 1, 0, 0, 4'b1011);
`endif
    tick("fwd_mem_rn");
    bus.sel_src1 = 2'b00; bus.sel_src2 = 2'b10; bus.fwd_wb_val = 32'hCAFE_0000;
    op(4'b0010, 0, 0, 32'h0000_0300, 32'h1111_1111, 12'h010, 4'd0, 0, 0, 1, 4'h0);
`ifdef EXE_FWD_EN
    push(32'h0000_0310, 32'hCAFE_0000, 4'd0, 0, 0, 1, 4'b1011);
`else
    push(32'h0000_0310, 32'h1111_1111, 4'd0, 0, 0, 1, 4'b1011);
`endif
    tick("fwd_wb_str");
    bus.sel_src1 = 2'b11; bus.sel_src2 = 2'b11;
    op(4'b0111, 0, 0, 32'h0000_0700, 32'h0000_0077, 12'h000, 4'd11, 1, 0, 0, 4'h0);
    push(32'h0000_0777, 32'h0000_0077, 4'd11, 1, 0, 0, 4'b1011); tick("sel11_reg");
    bus.sel_src1 = 2'b00; bus.sel_src2 = 2'b00;

    // Stall for two cycles while the inputs change
    stall = 1'b1;
    op(4'b0001, 1, 1, 32'h0, 32'h0, 12'h0AA, 4'd12, 1, 0, 0, 4'h0);
    push(last.alu, last.st, last.dest, last.wb, last.mr, last.mw, last.sr); tick("stall_1");
    op(4'b0010, 1, 1, 32'd5, 32'h5555, 12'h001, 4'd13, 0, 1, 0, 4'h0);
    push(last.alu, last.st, last.dest, last.wb, last.mr, last.mw, last.sr); tick("stall_2");
    stall = 1'b0;
    op(4'b0001, 1, 1, 32'h0, 32'h0, 12'h000, 4'd9, 1, 0, 0, 4'h0);
    push(32'h0, 32'h0, 4'd9, 1, 0, 0, 4'b0100); tick("unstall");

    op(4'h0, 0, 0, 32'h0, 32'h0, 12'h000, 4'd0, 0, 0, 0, 4'h0);
    push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0100); tick("bubble");

    // Asynchronous reset between edges
    op(4'b0001, 1, 1, 32'h0, 32'h0, 12'h055, 4'd5, 1, 0, 0, 4'b0011);
    push(32'h55, 32'h0, 4'd5, 1, 0, 0, 4'b0011); tick("pre_reset");
    #3; rst = 1'b1; #1;
    chk_cleared("reset_async");
    @(negedge clk); rst = 1'b0;
    push(32'h55, 32'h0, 4'd5, 1, 0, 0, 4'b0011); tick("post_reset");

    // Combinational branch target
    bus.b_in = 1'b1; bus.pc_in = 32'h100; bus.imm_signed_24 = 24'hFFFFFE; #1;
    chk("branch_taken", 32'(bus.branch_taken), 32'h1);
    chk("branch_back", bus.branch_addr, 32'h0000_00F8);
    bus.b_in = 1'b0; bus.pc_in = 32'h1000; bus.imm_signed_24 = 24'h000001; #1;
    chk("branch_not_taken", 32'(bus.branch_taken), 32'h0);
    chk("branch_fwd", bus.branch_addr, 32'h0000_1004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
